// File: rtl/godai_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// godai_mem_arbiter_if
// Bundles the req/gnt/rvalid bus signals around the Godai two-port-to-one
// memory arbiter: instruction requester, data requester and the unified
// memory side, plus the busy indicator.
//
// Signal suffixes follow the arbiter's point of view (_i = into arbiter).
//   instr_*  : instruction fetch requester (req/addr in, gnt/rvalid/rdata out)
//   data_*   : data requester (req/we/addr/be/wdata in,
//              gnt/rvalid/err/rdata out)
//   mem_*    : unified memory (req/we/addr/be/wdata out,
//              gnt/rvalid/err/rdata in)
//   busy_o   : arbiter has work in flight
//
// Modports:
//   slave  - the arbiter (serves both requesters, drives the memory bus)
//   master - the surrounding environment (core requesters + memory model)
// ---------------------------------------------------------------------------
interface godai_mem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    // Instruction side
    logic                  instr_req_i;
    logic [ADDR_WIDTH-1:0] instr_addr_i;
    logic                  instr_gnt_o;
    logic                  instr_rvalid_o;
    logic [DATA_WIDTH-1:0] instr_rdata_o;

    // Data side
    logic                  data_req_i;
    logic                  data_we_i;
    logic [ADDR_WIDTH-1:0] data_addr_i;
    logic [BE_WIDTH-1:0]   data_be_i;
    logic [DATA_WIDTH-1:0] data_wdata_i;
    logic                  data_gnt_o;
    logic                  data_rvalid_o;
    logic                  data_err_o;
    logic [DATA_WIDTH-1:0] data_rdata_o;

    // Memory side
    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [BE_WIDTH-1:0]   mem_be_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic                  mem_gnt_i;
    logic                  mem_rvalid_i;
    logic                  mem_err_i;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    logic                  busy_o;

    modport slave (
        input  instr_req_i, instr_addr_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        input  data_req_i, data_we_i, data_addr_i, data_be_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_err_i, mem_rdata_i,
        output busy_o
    );

    modport master (
        output instr_req_i, instr_addr_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        output data_req_i, data_we_i, data_addr_i, data_be_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_err_i, mem_rdata_i,
        input  busy_o
    );
endinterface

// File: rtl/godai_mem_arbiter.sv
// ---------------------------------------------------------------------------
// godai_mem_arbiter
// Merges the Godai instruction and data req/gnt/rvalid interfaces onto one
// unified memory. Data accesses win contention unless the instruction side
// has been denied STARVE_LIMIT consecutive cycles. A selection that is not
// yet granted by memory is held until granted. A small FIFO of source IDs
// (0 = instr, 1 = data) routes each in-order response back to its requester.
//
// Ports:
//   clk    - system clock, all state on rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - godai_mem_arbiter_if.slave: instr_*, data_*, mem_*, busy_o
// ---------------------------------------------------------------------------
module godai_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned STARVE_LIMIT    = 4
) (
    input logic                clk,
    input logic                rst_n,
    godai_mem_arbiter_if.slave bus
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned SCW      = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned CNW      = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PTW      = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);
    localparam logic [CNW-1:0] FIFO_FULL  = CNW'(MAX_OUTSTANDING);
    localparam logic [PTW-1:0] PTR_LAST   = PTW'(MAX_OUTSTANDING - 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD_I,
        HOLD_D
    } hold_e;

    hold_e                      r_hold;
    hold_e                      w_hold_nxt;
    logic [SCW-1:0]             r_starve_cnt;
    logic [MAX_OUTSTANDING-1:0] r_fifo;
    logic [PTW-1:0]             r_wptr;
    logic [PTW-1:0]             r_rptr;
    logic [CNW-1:0]             r_count;

    logic                  w_starve;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_sel_i;
    logic                  w_sel_d;
    logic                  w_mem_req;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_head;
    logic                  w_instr_gnt;
    logic                  w_data_gnt;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [BE_WIDTH-1:0]   w_mem_be;
    logic [DATA_WIDTH-1:0] w_mem_wdata;

    assign w_starve = (r_starve_cnt == STARVE_MAX);
    assign w_full   = (r_count == FIFO_FULL);
    assign w_empty  = (r_count == '0);

    // Selection and hold next-state. A full FIFO (or reset) suppresses the
    // request entirely without touching the hold state.
    always_comb begin : arbitrate
        w_sel_i    = 1'b0;
        w_sel_d    = 1'b0;
        w_hold_nxt = r_hold;

        case (r_hold)
            HOLD_I:  w_sel_i = 1'b1;
            HOLD_D:  w_sel_d = 1'b1;
            default: begin
                if (bus.instr_req_i && bus.data_req_i) begin
                    w_sel_i = w_starve;
                    w_sel_d = !w_starve;
                end else begin
                    w_sel_i = bus.instr_req_i;
                    w_sel_d = bus.data_req_i;
                end
            end
        endcase

        if (w_full || !rst_n) begin
            w_sel_i = 1'b0;
            w_sel_d = 1'b0;
        end

        if (w_sel_i || w_sel_d) begin
            if (bus.mem_gnt_i) begin
                w_hold_nxt = IDLE;
            end else begin
                w_hold_nxt = w_sel_i ? HOLD_I : HOLD_D;
            end
        end
    end

    assign w_mem_req   = w_sel_i | w_sel_d;
    assign w_instr_gnt = w_sel_i & bus.mem_gnt_i;
    assign w_data_gnt  = w_sel_d & bus.mem_gnt_i;
    assign w_push      = w_mem_req & bus.mem_gnt_i;
    // A response with nothing outstanding (e.g. issued before reset) is dropped.
    assign w_pop       = bus.mem_rvalid_i & !w_empty;
    assign w_head      = r_fifo[r_rptr];

    assign w_mem_addr  = w_sel_i ? bus.instr_addr_i :
                         w_sel_d ? bus.data_addr_i  : '0;
    assign w_mem_be    = w_sel_i ? '1 :
                         w_sel_d ? bus.data_be_i : '0;
    assign w_mem_wdata = w_sel_d ? bus.data_wdata_i : '0;

    always_ff @(posedge clk or negedge rst_n) begin : hold_reg
        if (!rst_n) begin
            r_hold <= IDLE;
        end else begin
            r_hold <= w_hold_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : starve_reg
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (w_instr_gnt) begin
            r_starve_cnt <= '0;
        end else if (bus.instr_req_i && !w_starve) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : route_fifo
        if (!rst_n) begin
            r_fifo  <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wptr] <= w_sel_d;
                r_wptr         <= (r_wptr == PTR_LAST) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PTR_LAST) ? '0 : r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.mem_req_o      = w_mem_req;
    assign bus.mem_we_o       = w_sel_d & bus.data_we_i;
    assign bus.mem_addr_o     = w_mem_addr;
    assign bus.mem_be_o       = w_mem_be;
    assign bus.mem_wdata_o    = w_mem_wdata;

    assign bus.instr_gnt_o    = w_instr_gnt;
    assign bus.data_gnt_o     = w_data_gnt;

    assign bus.instr_rvalid_o = w_pop & !w_head;
    assign bus.data_rvalid_o  = w_pop & w_head;
    assign bus.data_err_o     = w_pop & w_head & bus.mem_err_i;
    assign bus.instr_rdata_o  = bus.mem_rdata_i;
    assign bus.data_rdata_o   = bus.mem_rdata_i;

    assign bus.busy_o         = !w_empty | w_mem_req;
endmodule
